// File: rtl/dram_pkg.sv
// Shared types and default geometry for the line-to-word DRAM burst controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: default line geometry, the queued line request layout for that
// geometry, and the controller FSM state encoding.
package dram_pkg;

    // Default cache-line geometry; the controller derives its own values from
    // its LINE_BYTES parameter, which defaults to DRAM_LINE_BYTES.
    localparam int DRAM_LINE_BYTES = 64;
    localparam int DRAM_BEATS      = DRAM_LINE_BYTES / 8;
    localparam int DRAM_LINE_BITS  = DRAM_LINE_BYTES * 8;

    // One whole-line request from L2 at the default geometry.
    typedef struct packed {
        logic                      write;
        logic [63:0]               addr;
        logic [DRAM_LINE_BITS-1:0] wdata;
    } line_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/dram_req_fifo.sv
// Generic synchronous FIFO holding queued line requests.
// Latency: a pushed entry is visible on pop_dat the cycle after the push.
// Backpressure: pushes are dropped when full unless a pop happens that cycle; pops when empty are ignored.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset (empties the queue)
//   push_vld/push_dat write side
//   pop_rdy/pop_dat   read side; pop_dat always shows the head entry
//   full/empty        occupancy flags
module dram_req_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic push_vld,
    input  T     push_dat,
    input  logic pop_rdy,
    output T     pop_dat,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    // Pointers wrap explicitly so DEPTH need not fill the pointer range.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop_rdy && !empty;
    assign do_push = push_vld && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/dram_line_ctrl.sv
// Splits whole-line L2 fill/writeback requests into sequential 64-bit DRAM beats and returns one line response each.
// Latency: request accepted in cycle 0 pops in cycle 1, beat k issues in cycle 2+2k (1-cycle DRAM), response from cycle 2+2*BEATS.
// Backpressure: l2_req_ready drops while the request queue is full; a response is held stable until l2_resp_ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   l2_req_*                 line request in (valid/ready, write, addr, wdata)
//   l2_resp_*                line response out (valid/ready, write, rdata; rdata zero for write acks)
//   dram_req_*               one-beat DRAM request (valid, write, addr, wdata)
//   dram_resp_ready          mirrors dram_req_valid
//   dram_resp_valid/_rdata   DRAM beat completion and read data
//
// Build option: DRAM_CRITICAL_WORD_FIRST_EN starts fills at the requested
// beat and wraps; writebacks and the default build always start at beat 0.
module dram_line_ctrl
    import dram_pkg::*;
#(
    parameter int LINE_BYTES = DRAM_LINE_BYTES,
    parameter int QDEPTH     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    l2_req_valid,
    output logic                    l2_req_ready,
    input  logic                    l2_req_write,
    input  logic [63:0]             l2_req_addr,
    input  logic [LINE_BYTES*8-1:0] l2_req_wdata,
    output logic                    l2_resp_valid,
    input  logic                    l2_resp_ready,
    output logic                    l2_resp_write,
    output logic [LINE_BYTES*8-1:0] l2_resp_rdata,
    output logic                    dram_req_valid,
    output logic                    dram_req_write,
    output logic [63:0]             dram_req_addr,
    output logic [63:0]             dram_req_wdata,
    output logic                    dram_resp_ready,
    input  logic                    dram_resp_valid,
    input  logic [63:0]             dram_resp_rdata
);

    localparam int BEATS     = LINE_BYTES / 8;
    localparam int LINE_BITS = LINE_BYTES * 8;
    localparam int OFF_W     = $clog2(LINE_BYTES);
    localparam int IDX_W     = OFF_W - 3;

    typedef struct packed {
        logic                 write;
        logic [63:0]          addr;
        logic [LINE_BITS-1:0] wdata;
    } req_t;

    req_t               push_req;
    req_t               head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;

    ctrl_state_t        state;
    ctrl_state_t        state_nxt;

    logic               cur_write;
    logic [63-OFF_W:0]  cur_base;
    logic [LINE_BITS-1:0] cur_wdata;
    logic [IDX_W-1:0]   beat_cnt;
    logic [IDX_W-1:0]   beat_idx;
    logic [LINE_BITS-1:0] line_buf;
    logic               last_beat;
    logic               beat_done;

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    assign l2_req_ready   = !fifo_full;
    assign push_req.write = l2_req_write;
    assign push_req.addr  = l2_req_addr;
    assign push_req.wdata = l2_req_wdata;

    dram_req_fifo #(
        .DEPTH (QDEPTH),
        .T     (req_t)
    ) u_req_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (l2_req_valid && l2_req_ready),
        .push_dat (push_req),
        .pop_rdy  (fifo_pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Beat ordering
    // ------------------------------------------------------------------
`ifdef DRAM_CRITICAL_WORD_FIRST_EN
    logic [IDX_W-1:0] start_idx;
    logic             unused_addr_bits;

    // Fill wraps from the critical beat; IDX_W-bit addition is the mod BEATS.
    assign beat_idx         = start_idx + beat_cnt;
    assign unused_addr_bits = ^head.addr[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            start_idx <= '0;
        end else if (fifo_pop) begin
            start_idx <= head.write ? '0 : head.addr[OFF_W-1:3];
        end
    end
`else
    logic unused_addr_bits;

    assign beat_idx         = beat_cnt;
    assign unused_addr_bits = ^head.addr[OFF_W-1:0];
`endif

    assign last_beat = (beat_cnt == IDX_W'(BEATS - 1));
    assign beat_done = (state == ST_WAIT) && dram_resp_valid;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        fifo_pop       = 1'b0;
        dram_req_valid = 1'b0;
        l2_resp_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                dram_req_valid = 1'b1;
                state_nxt      = ST_WAIT;
            end
            ST_WAIT: begin
                if (dram_resp_valid) begin
                    state_nxt = last_beat ? ST_RESP : ST_ISSUE;
                end
            end
            ST_RESP: begin
                l2_resp_valid = 1'b1;
                if (l2_resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Working registers and line buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_write <= 1'b0;
            cur_base  <= '0;
            cur_wdata <= '0;
            beat_cnt  <= '0;
            line_buf  <= '0;
        end else begin
            if (fifo_pop) begin
                cur_write <= head.write;
                cur_base  <= head.addr[63:OFF_W];
                cur_wdata <= head.wdata;
                beat_cnt  <= '0;
            end
            if (beat_done) begin
                // Write beats return pre-write data, which is not wanted.
                if (!cur_write) begin
                    line_buf[int'(beat_idx)*64 +: 64] <= dram_resp_rdata;
                end
                if (!last_beat) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: everything is zero outside the state that owns it
    // ------------------------------------------------------------------
    assign dram_resp_ready = dram_req_valid;
    assign dram_req_write  = dram_req_valid && cur_write;
    assign dram_req_addr   = dram_req_valid ? {cur_base, beat_idx, 3'b000} : 64'd0;
    assign dram_req_wdata  = dram_req_valid ? cur_wdata[int'(beat_idx)*64 +: 64] : 64'd0;

    assign l2_resp_write   = l2_resp_valid && cur_write;
    assign l2_resp_rdata   = (l2_resp_valid && !cur_write) ? line_buf : '0;

endmodule
